// File: rtl/video_timing_pkg.sv
// Shared video timing constants and helpers for the DVI PMOD timing generators.
// Standard mode tables plus total-period helpers.
package video_timing_pkg;

  // SVGA 800x600@60, 40 MHz dot clock
  localparam int unsigned SVGA_H_ACTIVE = 800;
  localparam int unsigned SVGA_H_FP     = 40;
  localparam int unsigned SVGA_H_SYNC   = 128;
  localparam int unsigned SVGA_H_BP     = 88;
  localparam int unsigned SVGA_V_ACTIVE = 600;
  localparam int unsigned SVGA_V_FP     = 1;
  localparam int unsigned SVGA_V_SYNC   = 4;
  localparam int unsigned SVGA_V_BP     = 23;

  // VGA 640x480@60, 25.175 MHz dot clock
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned FRAME_CNT_W = 16;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } sync_bits_t;

  function automatic int unsigned h_total(int unsigned active, int unsigned fp,
                                          int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(int unsigned active, int unsigned fp,
                                          int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register aligning sync/DE with the pixel data pipeline.
// Each bit has its own reset value so sync lines flush to their inactive level.
module sync_delay_line #(
  parameter int unsigned     WIDTH   = 3,
  parameter int unsigned     DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_dot,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_dot) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: pixel request stream plus DE/sync outputs
// delayed to line up with pixel data at the output registers.
module vga_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = SVGA_H_ACTIVE,
  parameter int unsigned H_FP        = SVGA_H_FP,
  parameter int unsigned H_SYNC      = SVGA_H_SYNC,
  parameter int unsigned H_BP        = SVGA_H_BP,
  parameter int unsigned V_ACTIVE    = SVGA_V_ACTIVE,
  parameter int unsigned V_FP        = SVGA_V_FP,
  parameter int unsigned V_SYNC      = SVGA_V_SYNC,
  parameter int unsigned V_BP        = SVGA_V_BP,
  parameter bit          HS_POL      = 1'b1,
  parameter bit          VS_POL      = 1'b1,
  parameter int unsigned PIX_LATENCY = 2,
  parameter int unsigned CW          = 12
) (
  input  logic                   clk_dot,
  input  logic                   reset,
  input  logic                   enable,
  output logic [CW-1:0]          x,
  output logic [CW-1:0]          y,
  output logic                   req,
  output logic                   line_start,
  output logic                   frame_start,
  output logic                   vga_active,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $fatal(1, "vga_timing_gen: porch and sync parameters must be at least 1");
  end
  if (H_TOTAL >= 2**CW || V_TOTAL >= 2**CW) begin : g_bad_total
    $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end
  if (PIX_LATENCY < 1 || PIX_LATENCY > 16) begin : g_bad_latency
    $fatal(1, "vga_timing_gen: PIX_LATENCY must be in 1..16");
  end

  logic                   enable_q;
  logic [CW-1:0]          h_cnt_q, h_cnt_d;
  logic [CW-1:0]          v_cnt_q, v_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   h_last, v_last;
  sync_bits_t             raw;
  logic [2:0]             dly_in, dly_out;

  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);

  // Counters only advance while both the registered and the live enable are
  // high, so a drop zeroes them on the same edge that clears enable_q.
  always_comb begin
    h_cnt_d     = '0;
    v_cnt_d     = '0;
    frame_cnt_d = frame_cnt_q;
    if (enable && enable_q) begin
      if (h_last) begin
        v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
      end
    end
    if (enable_q && h_last && v_last) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_dot) begin
    if (reset) begin
      enable_q    <= 1'b0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      enable_q    <= enable;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    raw.active = enable_q && (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    raw.hsync  = enable_q && (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
    raw.vsync  = enable_q && (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign req         = raw.active;
  assign line_start  = enable_q && (h_cnt_q == '0);
  assign frame_start = enable_q && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign frame_cnt   = frame_cnt_q;

  // Polarity is folded in ahead of the delay line so the pins come straight
  // off flops and reset flushes each sync to its own inactive level.
  assign dly_in = {raw.active, raw.hsync ~^ HS_POL, raw.vsync ~^ VS_POL};

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIX_LATENCY),
    .RST_VAL ({1'b0, ~HS_POL, ~VS_POL})
  ) u_sync_delay_line (
    .clk_dot (clk_dot),
    .reset   (reset),
    .din     (dly_in),
    .dout    (dly_out)
  );

  assign vga_active = dly_out[2];
  assign vga_hsync  = dly_out[1];
  assign vga_vsync  = dly_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in a small 16x8 mode, positive and negative
// sync polarity instances driven side by side.
module tb_vga_timing_gen;

  localparam int unsigned CW = 12;
  localparam int LAT = 3;

  logic          clk_dot = 1'b0;
  logic          reset;
  logic          enable;

  logic [CW-1:0] x_a, y_a, x_b, y_b;
  logic          req_a, ls_a, fs_a, act_a, hs_a, vs_a;
  logic          req_b, ls_b, fs_b, act_b, hs_b, vs_b;
  logic [15:0]   fc_a, fc_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_dot = ~clk_dot;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LATENCY(LAT), .CW(CW)
  ) dut (
    .clk_dot(clk_dot), .reset(reset), .enable(enable),
    .x(x_a), .y(y_a), .req(req_a), .line_start(ls_a), .frame_start(fs_a),
    .vga_active(act_a), .vga_hsync(hs_a), .vga_vsync(vs_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LATENCY(LAT), .CW(CW)
  ) dut_neg (
    .clk_dot(clk_dot), .reset(reset), .enable(enable),
    .x(x_b), .y(y_b), .req(req_b), .line_start(ls_b), .frame_start(fs_b),
    .vga_active(act_b), .vga_hsync(hs_b), .vga_vsync(vs_b), .frame_cnt(fc_b)
  );

  task automatic step();
    @(posedge clk_dot);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raw decode of the small mode at cycle k of a run; k < 0 is idle.
  function automatic logic m_act(int k);
    if (k < 0) return 1'b0;
    return ((k % 16) < 8) && (((k / 16) % 8) < 4);
  endfunction

  function automatic logic m_hs(int k);
    if (k < 0) return 1'b0;
    return ((k % 16) >= 10) && ((k % 16) < 13);
  endfunction

  function automatic logic m_vs(int k);
    if (k < 0) return 1'b0;
    return (((k / 16) % 8) >= 5) && (((k / 16) % 8) < 7);
  endfunction

  task automatic check_cycle(int k, logic [15:0] fc_exp);
    int h;
    int v;
    h = k % 16;
    v = (k / 16) % 8;
    chk($sformatf("x k=%0d", k), 32'(x_a), 32'(h));
    chk($sformatf("y k=%0d", k), 32'(y_a), 32'(v));
    chk($sformatf("req k=%0d", k), 32'(req_a), 32'(m_act(k)));
    chk($sformatf("line_start k=%0d", k), 32'(ls_a), 32'(h == 0));
    chk($sformatf("frame_start k=%0d", k), 32'(fs_a), 32'(h == 0 && v == 0));
    chk($sformatf("vga_active k=%0d", k), 32'(act_a), 32'(m_act(k - LAT)));
    chk($sformatf("vga_hsync k=%0d", k), 32'(hs_a), 32'(m_hs(k - LAT)));
    chk($sformatf("vga_vsync k=%0d", k), 32'(vs_a), 32'(m_vs(k - LAT)));
    chk($sformatf("frame_cnt k=%0d", k), 32'(fc_a), 32'(fc_exp));
    chk($sformatf("neg_hsync k=%0d", k), 32'(hs_b), 32'(!m_hs(k - LAT)));
    chk($sformatf("neg_vsync k=%0d", k), 32'(vs_b), 32'(!m_vs(k - LAT)));
  endtask

  initial begin
    int cnt_req;
    int cnt_act;
    int cnt_hs;
    int cnt_vs;
    int fs_first;
    int fs_second;

    cnt_req   = 0;
    cnt_act   = 0;
    cnt_hs    = 0;
    cnt_vs    = 0;
    fs_first  = -1;
    fs_second = -1;

    // Reset with enable already high
    reset  = 1'b1;
    enable = 1'b1;
    step();
    step();
    chk("rst x", 32'(x_a), 0);
    chk("rst y", 32'(y_a), 0);
    chk("rst req", 32'(req_a), 0);
    chk("rst frame_start", 32'(fs_a), 0);
    chk("rst frame_cnt", 32'(fc_a), 0);
    chk("rst vga_active", 32'(act_a), 0);
    chk("rst vga_hsync", 32'(hs_a), 0);
    chk("rst vga_vsync", 32'(vs_a), 0);
    chk("rst neg_hsync", 32'(hs_b), 1);
    chk("rst neg_vsync", 32'(vs_b), 1);

    // First enabled frame plus two lines into the next one
    reset = 1'b0;
    step();
    for (int k = 0; k <= 165; k++) begin
      check_cycle(k, (k >= 128) ? 16'd1 : 16'd0);
      if (k < 16) begin
        cnt_req += int'(req_a);
        cnt_act += int'(act_a);
        cnt_hs  += int'(hs_a);
      end
      cnt_vs += int'(vs_a);
      if (fs_a && fs_first < 0) fs_first = k;
      else if (fs_a && fs_second < 0) fs_second = k;
      if (k < 165) step();
    end
    chk("req cycles line0", 32'(cnt_req), 8);
    chk("vga_active cycles line0", 32'(cnt_act), 8);
    chk("vga_hsync cycles line0", 32'(cnt_hs), 3);
    chk("vga_vsync cycles frame", 32'(cnt_vs), 32);
    chk("frame period", 32'(fs_second - fs_first), 128);

    // Drop enable at h=5, v=2
    enable = 1'b0;
    step();
    chk("drop x", 32'(x_a), 0);
    chk("drop y", 32'(y_a), 0);
    chk("drop req", 32'(req_a), 0);
    chk("drop line_start", 32'(ls_a), 0);
    chk("drop frame_start", 32'(fs_a), 0);
    chk("drop vga_active +1", 32'(act_a), 1);
    step();
    step();
    chk("drop vga_active +3", 32'(act_a), 1);
    step();
    chk("drop vga_active +4", 32'(act_a), 0);
    chk("drop frame_cnt", 32'(fc_a), 1);
    step();
    step();
    chk("idle x", 32'(x_a), 0);
    chk("idle vga_hsync", 32'(hs_a), 0);
    chk("idle neg_hsync", 32'(hs_b), 1);

    // Re-enable: restart at (0,0) with frame_cnt preserved, then force a wrap
    enable = 1'b1;
    step();
    check_cycle(0, 16'd1);
    force dut.frame_cnt_q = 16'hFFFF;
    step();
    for (int k = 1; k <= 236; k++) begin
      check_cycle(k, (k >= 128) ? 16'h0000 : 16'hFFFF);
      if (k == 126) release dut.frame_cnt_q;
      if (k < 236) step();
    end

    // Reset at h=12, v=6, inside both sync windows
    reset = 1'b1;
    step();
    chk("mid rst x", 32'(x_a), 0);
    chk("mid rst y", 32'(y_a), 0);
    chk("mid rst req", 32'(req_a), 0);
    chk("mid rst frame_cnt", 32'(fc_a), 0);
    chk("mid rst vga_active", 32'(act_a), 0);
    chk("mid rst vga_hsync", 32'(hs_a), 0);
    chk("mid rst vga_vsync", 32'(vs_a), 0);
    chk("mid rst neg_hsync", 32'(hs_b), 1);
    chk("mid rst neg_vsync", 32'(vs_b), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised video timing generator for the DVI PMOD designs, replacing the fixed-mode timing inside the existing VGA core. It produces a pixel request stream (x, y, req, line and frame strobes) for the pattern/pixel logic. It also produces de/hsync/vsync delayed by a configurable pipeline latency, so that sync lines up with pixel data at the DDR output registers. Timing, sync polarity and latency are compile-time parameters. Runtime enable and a frame counter are added.

## Interface
- H_ACTIVE, 800: active pixels per line
- H_FP, 40: horizontal front porch, in pixels
- H_SYNC, 128: hsync width, in pixels
- H_BP, 88: horizontal back porch, in pixels
- V_ACTIVE, 600: active lines per frame
- V_FP, 1: vertical front porch, in lines
- V_SYNC, 4: vsync width, in lines
- V_BP, 23: vertical back porch, in lines
- HS_POL, 1: hsync active level (1 = active high)
- VS_POL, 1: vsync active level (1 = active high)
- PIX_LATENCY, 2: delay of the vga_* outputs relative to req, in cycles; legal range 1..16
- CW, 12: width of the x/y counters

Ports:
- clk_dot  in  1  pixel clock; everything is in this domain
- reset  in  1  synchronous, active-high
- enable  in  1  run/hold
- x  out  CW  horizontal counter value
- y  out  CW  vertical counter value
- req  out  1  current (x, y) is an active pixel
- line_start  out  1  high when x = 0 and enable is high
- frame_start  out  1  high when x = 0, y = 0 and enable is high
- vga_active  out  1  data enable, delayed by PIX_LATENCY
- vga_hsync  out  1  hsync, delayed, polarity per HS_POL
- vga_vsync  out  1  vsync, delayed, polarity per VS_POL
- frame_cnt  out  16  count of completed frames

## Operation
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP. V_TOTAL is defined the same way for the vertical parameters.
- h_cnt counts 0 .. H_TOTAL-1, then wraps to 0. v_cnt increments on each h wrap and wraps to 0 after V_TOTAL-1.
- x = h_cnt and y = v_cnt at all times, including during blanking.
- req = enable_q & (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE).
- Raw hsync is high when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- Raw vsync is high for every cycle of lines V_ACTIVE+V_FP .. V_ACTIVE+V_FP+V_SYNC-1, aligned to h_cnt = 0.
- Both raw syncs are gated by enable_q.
- Raw {req, hsync, vsync} feed a shift register of depth PIX_LATENCY.
- Polarity is applied at the output: vga_hsync = HS_POL ? hs_d : ~hs_d. vga_vsync follows the same rule with VS_POL.
- frame_cnt increments by 1 (modulo 2^16) in the cycle where h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1 and enable_q = 1.
- enable is registered into enable_q. While enable_q = 0:
  - h_cnt and v_cnt are held at 0.
  - req, line_start and frame_start are 0.
  - Inactive levels keep shifting through the delay line.
- The first cycle with enable_q = 1 has h = 0, v = 0, with frame_start = 1 and line_start = 1.
- Dropping enable mid-frame abandons the frame. The next enable always restarts at (0, 0).
- Parameter check at elaboration: every porch and sync parameter must be at least 1, and H_TOTAL and V_TOTAL must each be below 2^CW. A violation is a fatal error.

## Timing
- Reset is synchronous. In the cycle after reset is sampled high:
  - h_cnt = 0, v_cnt = 0, frame_cnt = 0, enable_q = 0.
  - The delay line is flushed to inactive: vga_active = 0, vga_hsync = ~HS_POL, vga_vsync = ~VS_POL.
- These reset values hold until PIX_LATENCY cycles after the first active-enable cycle.
- x, y, req and the strobes are decoded from the counter registers: zero latency relative to the counter state.
- The vga_* outputs are registered. Each one equals the raw decode from exactly PIX_LATENCY cycles earlier.
- Latency from enable to the first req is 1 cycle.
- Reset takes priority over enable. Reset mid-frame restarts everything at the next cycle.
- Frame length is exactly H_TOTAL × V_TOTAL cycles, with no dead cycles at the line or frame wrap.

## Structure
- Shared package video_timing_pkg:
  - SVGA 800x600@60 constants (40 MHz), used as the defaults.
  - VGA 640x480@60 constants (25.175 MHz).
  - H_TOTAL/V_TOTAL helper functions.
- One sub-module, sync_delay_line: parameters WIDTH = 3, DEPTH = PIX_LATENCY, and a per-bit reset value vector.
- The counters, decode and frame_cnt stay in vga_timing_gen.

## Test plan
Small-mode bench parameters: H 8/2/3/3 (H_TOTAL = 16), V 4/1/2/1 (V_TOTAL = 8), PIX_LATENCY = 3, polarity positive.

1. Release reset with enable = 1.
   - Cycle +1 after enable_q: x = 0, y = 0, frame_start = line_start = req = 1.
   - vga_active first goes high 3 cycles later and is 0 before that.
2. Observe one line. Required response:
   - req is high for h = 0..7.
   - vga_hsync is high for exactly 3 cycles, starting 3 cycles after h = 10.
   - vga_active is high for 8 cycles per line.
3. Run one full frame. Required response:
   - vga_vsync is high for exactly 32 cycles (lines 5–6).
   - Frame period is 128 cycles.
   - frame_cnt goes 0 → 1 at the frame wrap, and wraps from 0xFFFF to 0 when forced.
4. HS_POL = 0, VS_POL = 0. Required response:
   - During reset: vga_hsync = 1, vga_vsync = 1.
   - Both syncs go low only during the sync windows.
5. Drop enable at h = 5, v = 2. Required response:
   - Next cycle: x = 0, y = 0, req = 0.
   - vga_active falls after 3 cycles.
   - On re-enable: frame_start = 1 at (0, 0); frame_cnt is unchanged.
6. Assert reset mid-frame at h = 12, v = 6 (inside hsync and vsync). Required response:
   - Next cycle: all vga_* are inactive immediately, frame_cnt = 0, counters = 0.
